ftdi_sync_device: RTL and testbench
===================================

// Module: ftdi_sync_device
// PURPOSE
//  FT245-style synchronous FIFO device: the chip end of the FTDI sync bus that ftdi_sync drives.
//  Drives RXF#/TXE#/read data; consumes RD#/WR#/OE#/write data.
//  Its USB-side streams are the "PC end": usb_in (bytes the host will read), usb_out (bytes the host wrote).
//  Used as a synthesizable loopback/emulation target and as the bus model in ftdi_sync benches.
// PARAMETERS
//  DEPTH     64  bytes per direction FIFO (power of two)
//  ADDR_W    6   log2(DEPTH)
//  COUNT_W   7   ADDR_W+1
//  RX_BURST  0   max bytes per RXF# assertion; 0 = unlimited
//  RX_GAP    2   cycles RXF# is forced high after a completed burst (>=1)
// PORTS
//  clk_i            in   1  bus clock (CLKOUT domain)
//  rst_ni           in   1  async reset, active low
//  ftdi_rdn_i       in   1  RD#, active low
//  ftdi_wrn_i       in   1  WR#, active low
//  ftdi_oen_i       in   1  OE#, active low
//  ftdi_siwua_i     in   1  send-immediate; ignored, sampled for error check only
//  ftdi_data_in_i   in   8  write data from host
//  ftdi_rxf_o       out  1  RXF#: 0 = byte available to read
//  ftdi_txe_o       out  1  TXE#: 0 = space to accept a write
//  ftdi_data_out_o  out  8  read data to host
//  ftdi_data_oe_o   out  1  pad drive enable for ftdi_data_out_o
//  usb_in_valid_i   in   1  PC->host byte valid
//  usb_in_data_i    in   8  PC->host byte
//  usb_in_accept_o  out  1  PC->host byte accepted
//  usb_out_valid_o  out  1  host->PC byte valid
//  usb_out_data_o   out  8  host->PC byte
//  usb_out_accept_i in   1  host->PC byte consumed
//  proto_err_o      out  3  sticky protocol error flags
// BEHAVIOUR
//  Reset: one clock (clk_i); rst_ni asynchronous, active low. Async-clears both FIFOs, ready_q=0, burst/gap counters=0, rx FSM=RX_OPEN, proto_err_o=0.
//  Reset outputs: rxf_o=1, txe_o=1, data_out_o=0, data_oe_o=!oen_i, usb_in_accept_o=0, usb_out_valid_o=0.
//  ready_q sets 1 on first edge after reset release; rxf_o/txe_o stay 1 while ready_q=0.
//  Read path (in-FIFO, DEPTH x 8):
//  - usb_in push when usb_in_valid_i & usb_in_accept_o; accept = !full.
//  - rxf_o = !ready_q | in_empty | (rx_state==RX_GAP).
//  - ftdi_data_out_o = in-FIFO head, 0 when empty. Combinational from registers, no OE# delay.
//  - Pop on edge where rdn_i==0 & rxf_o==0. Matches ftdi_sync push rule, so no byte lost or duplicated.
//  - Push and pop in the same cycle: level unchanged.
//  - ftdi_data_oe_o = !ftdi_oen_i.
//  RX FSM (burst shaping, active only when RX_BURST!=0):
//  - RX_OPEN: each pop does burst_cnt++. Pop when burst_cnt==RX_BURST-1 -> RX_GAP, gap_cnt=RX_GAP-1, burst_cnt=0.
//  - RX_GAP: gap_cnt-- each cycle; at 0 -> RX_OPEN. RD# low during the gap is legal and pops nothing.
//  - RX_BURST==0: FSM held in RX_OPEN.
//  Write path (out-FIFO, DEPTH x 8):
//  - txe_o = !ready_q | out_full.
//  - Capture ftdi_data_in_i on edge where wrn_i==0 & txe_o==0.
//  - Capture on the edge that fills the FIFO is accepted. txe_o goes 1 next cycle; later WR# low is ignored.
//  - usb_out_valid_o = !out_empty; pop on usb_out_valid_o & usb_out_accept_i.
//  proto_err_o (sticky until reset):
//  - [0] rdn_i==0 while oen_i==1 (read without OE#).
//  - [1] rdn_i==0 & wrn_i==0 same cycle.
//  - [2] oen_i==0 & wrn_i==0 (bus contention).
//  - Errors never block data movement.
//  Reset mid-transfer: all buffered bytes discarded, no partial-burst state retained.
// STRUCTURE
//  Sub-module: ftdi_fifo, two instances (in/out), unchanged.
//  Shared package ftdi_pkg: rx FSM state enum (RX_OPEN, RX_GAP).
//  ftdi_pkg also holds ERR_RD_NO_OE=0, ERR_RD_WR=1, ERR_OE_WR=2 and FTDI_DATA_W=8.
//  This module holds the FSM, counters, ready_q, error flags and glue.
// TESTING
//  1) Reset: hold rst_ni=0 and push usb_in 0xA5 -> rxf_o=1, txe_o=1, accept=0, proto_err_o=0.
//  2) Push 0x01..0x05 on usb_in; host drives OE#,RD# low -> 0x01..0x05 on data_out at 5 edges, rxf_o=1 after 5th.
//  3) RX_BURST=4, RX_GAP=2, 10 bytes queued, RD# held low -> 4 bytes, rxf_o high 2 cycles, repeat; bytes 1..10 in order.
//  4) usb_out_accept_i=0, host writes 70 bytes -> 64 captured, txe_o=1 from cycle after 64th.
//     Then accept=1 -> 0..63 out in order, txe_o returns 0.
//  5) Simultaneous usb_in push and host pop at level 1 -> level stays 1, rxf_o stays 0, correct head.
//  6) RD# low with OE# high, then RD#&WR# low -> proto_err_o=3'b001 then 3'b011, sticky until rst_ni.
//  7) Back-to-back with ftdi_sync instance: 1000 random bytes each way, random backpressure.
//     Expect loss-free, ordered transfer and proto_err_o==0.

Source files
------------

// File: rtl/ftdi_pkg.sv
// rtl/ftdi_pkg.sv - shared types and constants for the FTDI sync bus device
package ftdi_pkg;

  localparam int FTDI_DATA_W = 8;

  // Bit positions inside the sticky protocol error vector
  localparam int ERR_RD_NO_OE = 0;
  localparam int ERR_RD_WR    = 1;
  localparam int ERR_OE_WR    = 2;

  // Read-side burst shaping state
  typedef enum logic [0:0] {
    RX_OPEN = 1'b0,
    RX_GAP  = 1'b1
  } rx_state_e;

endpackage

// File: rtl/ftdi_fifo.sv
// rtl/ftdi_fifo.sv - byte FIFO with async-cleared pointers and zero-when-empty head
module ftdi_fifo
  import ftdi_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6,
  parameter int PTR_W  = 7
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [FTDI_DATA_W-1:0] data_i,
  input  logic                   pop_i,
  output logic [FTDI_DATA_W-1:0] data_o,
  output logic                   empty_o,
  output logic                   full_o
);

  logic [FTDI_DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic                   do_push;
  logic                   do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  assign empty_o = (wr_ptr == rd_ptr);
  assign full_o  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                   (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = empty_o ? '0 : mem[rd_ptr[ADDR_W-1:0]];

  // Storage array: written only on accepted pushes, never reset
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr[ADDR_W-1:0]] <= data_i;
    end
  end

  // Pointer advance; reset empties the FIFO regardless of stored contents
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ftdi_sync_device.sv
// rtl/ftdi_sync_device.sv - FT245-style synchronous FIFO chip end of the FTDI sync bus
module ftdi_sync_device
  import ftdi_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int ADDR_W   = 6,
  parameter int COUNT_W  = 7,
  parameter int RX_BURST = 0,
  parameter int RX_GAP   = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   ftdi_rdn_i,
  input  logic                   ftdi_wrn_i,
  input  logic                   ftdi_oen_i,
  input  logic                   ftdi_siwua_i,
  input  logic [FTDI_DATA_W-1:0] ftdi_data_in_i,
  output logic                   ftdi_rxf_o,
  output logic                   ftdi_txe_o,
  output logic [FTDI_DATA_W-1:0] ftdi_data_out_o,
  output logic                   ftdi_data_oe_o,
  input  logic                   usb_in_valid_i,
  input  logic [FTDI_DATA_W-1:0] usb_in_data_i,
  output logic                   usb_in_accept_o,
  output logic                   usb_out_valid_o,
  output logic [FTDI_DATA_W-1:0] usb_out_data_o,
  input  logic                   usb_out_accept_i,
  output logic [2:0]             proto_err_o
);

  // Counter widths sized to hold RX_BURST-1 and RX_GAP-1
  localparam int BURST_W = (RX_BURST > 2) ? $clog2(RX_BURST) : 1;
  localparam int GAP_W   = (RX_GAP > 2) ? $clog2(RX_GAP) : 1;

  logic                   ready_q;
  rx_state_e              rx_state;
  logic [BURST_W-1:0]     burst_cnt;
  logic [GAP_W-1:0]       gap_cnt;
  logic [2:0]             err_q;

  logic                   in_empty;
  logic                   in_full;
  logic                   in_push;
  logic                   in_pop;
  logic [FTDI_DATA_W-1:0] in_head;

  logic                   out_empty;
  logic                   out_full;
  logic                   out_push;
  logic                   out_pop;

  // Send-immediate has no effect on this model
  logic                   unused_siwua;
  assign unused_siwua = ftdi_siwua_i;

  // Bus-side flags: both held inactive until the first edge after reset
  assign ftdi_rxf_o = !ready_q || in_empty || (rx_state == ftdi_pkg::RX_GAP);
  assign ftdi_txe_o = !ready_q || out_full;

  assign ftdi_data_out_o = in_head;
  assign ftdi_data_oe_o  = !ftdi_oen_i;

  // A byte moves on the bus exactly when the host strobe meets an active flag
  assign in_pop   = !ftdi_rdn_i && !ftdi_rxf_o;
  assign out_push = !ftdi_wrn_i && !ftdi_txe_o;

  assign usb_in_accept_o = ready_q && !in_full;
  assign in_push         = usb_in_valid_i && usb_in_accept_o;

  assign usb_out_valid_o = !out_empty;
  assign out_pop         = usb_out_valid_o && usb_out_accept_i;

  assign proto_err_o = err_q;

  ftdi_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .PTR_W  (COUNT_W)
  ) u_in_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (in_push),
    .data_i  (usb_in_data_i),
    .pop_i   (in_pop),
    .data_o  (in_head),
    .empty_o (in_empty),
    .full_o  (in_full)
  );

  ftdi_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .PTR_W  (COUNT_W)
  ) u_out_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (out_push),
    .data_i  (ftdi_data_in_i),
    .pop_i   (out_pop),
    .data_o  (usb_out_data_o),
    .empty_o (out_empty),
    .full_o  (out_full)
  );

  // Ready flag: rises on the first clock after reset release
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= 1'b1;
    end
  end

  // Burst shaping: after RX_BURST pops, force RXF# high for RX_GAP cycles
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state  <= ftdi_pkg::RX_OPEN;
      burst_cnt <= '0;
      gap_cnt   <= '0;
    end else if (RX_BURST != 0) begin
      case (rx_state)
        ftdi_pkg::RX_OPEN: begin
          if (in_pop) begin
            if (burst_cnt == BURST_W'(RX_BURST - 1)) begin
              rx_state  <= ftdi_pkg::RX_GAP;
              gap_cnt   <= GAP_W'(RX_GAP - 1);
              burst_cnt <= '0;
            end else begin
              burst_cnt <= burst_cnt + 1'b1;
            end
          end
        end
        ftdi_pkg::RX_GAP: begin
          if (gap_cnt == '0) begin
            rx_state <= ftdi_pkg::RX_OPEN;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: begin
          rx_state <= ftdi_pkg::RX_OPEN;
        end
      endcase
    end
  end

  // Sticky protocol error flags; they only report, never gate traffic
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= '0;
    end else begin
      if (!ftdi_rdn_i && ftdi_oen_i) begin
        err_q[ERR_RD_NO_OE] <= 1'b1;
      end
      if (!ftdi_rdn_i && !ftdi_wrn_i) begin
        err_q[ERR_RD_WR] <= 1'b1;
      end
      if (!ftdi_oen_i && !ftdi_wrn_i) begin
        err_q[ERR_OE_WR] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ftdi_sync_device.sv
// tb/tb_ftdi_sync_device.sv - self-checking bench for ftdi_sync_device
module tb_ftdi_sync_device;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // Instance A: default parameters (unlimited bursts)
  logic       rdn, wrn, oen, uv, acc;
  logic [7:0] ud, wd;
  logic       rxf, txe, doe, uacc, uovalid;
  logic [7:0] dout, uodata;
  logic [2:0] err;

  // Instance B: RX_BURST=4, RX_GAP=2, read path only
  logic       rdn_b, oen_b, uv_b;
  logic [7:0] ud_b;
  logic       rxf_b, txe_b, doe_b, uacc_b, uovalid_b;
  logic [7:0] dout_b, unused_uodata_b;
  logic [2:0] err_b;

  ftdi_sync_device dut_a (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .ftdi_rdn_i       (rdn),
    .ftdi_wrn_i       (wrn),
    .ftdi_oen_i       (oen),
    .ftdi_siwua_i     (1'b0),
    .ftdi_data_in_i   (wd),
    .ftdi_rxf_o       (rxf),
    .ftdi_txe_o       (txe),
    .ftdi_data_out_o  (dout),
    .ftdi_data_oe_o   (doe),
    .usb_in_valid_i   (uv),
    .usb_in_data_i    (ud),
    .usb_in_accept_o  (uacc),
    .usb_out_valid_o  (uovalid),
    .usb_out_data_o   (uodata),
    .usb_out_accept_i (acc),
    .proto_err_o      (err)
  );

  ftdi_sync_device #(.RX_BURST(4), .RX_GAP(2)) dut_b (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .ftdi_rdn_i       (rdn_b),
    .ftdi_wrn_i       (1'b1),
    .ftdi_oen_i       (oen_b),
    .ftdi_siwua_i     (1'b0),
    .ftdi_data_in_i   (8'h00),
    .ftdi_rxf_o       (rxf_b),
    .ftdi_txe_o       (txe_b),
    .ftdi_data_out_o  (dout_b),
    .ftdi_data_oe_o   (doe_b),
    .usb_in_valid_i   (uv_b),
    .usb_in_data_i    (ud_b),
    .usb_in_accept_o  (uacc_b),
    .usb_out_valid_o  (uovalid_b),
    .usb_out_data_o   (unused_uodata_b),
    .usb_out_accept_i (1'b0),
    .proto_err_o      (err_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Scoreboard for instance A
  logic [7:0] rd_q[$];
  logic [7:0] wr_q[$];
  logic       m_ready;
  logic [2:0] m_err;

  typedef struct {
    logic       rdn;
    logic       wrn;
    logic       oen;
    logic [2:0] err_after;
  } vec_t;
  vec_t vt[5];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle on instance A: drive, check against the model, advance the model
  task automatic step(input logic i_rdn, input logic i_wrn, input logic i_oen,
                      input logic i_uv, input logic [7:0] i_ud,
                      input logic [7:0] i_wd, input logic i_acc);
    logic e_rxf, e_txe, e_uacc;
    @(negedge clk);
    rdn = i_rdn; wrn = i_wrn; oen = i_oen; uv = i_uv; ud = i_ud; wd = i_wd; acc = i_acc;
    #1;
    e_rxf  = !m_ready || (rd_q.size() == 0);
    e_txe  = !m_ready || (wr_q.size() == 64);
    e_uacc = m_ready && (rd_q.size() < 64);
    chk("rxf", {7'b0, rxf}, {7'b0, e_rxf});
    chk("txe", {7'b0, txe}, {7'b0, e_txe});
    chk("usb_in_accept", {7'b0, uacc}, {7'b0, e_uacc});
    chk("data_out", dout, (rd_q.size() != 0) ? rd_q[0] : 8'h00);
    chk("data_oe", {7'b0, doe}, {7'b0, !i_oen});
    chk("usb_out_valid", {7'b0, uovalid}, {7'b0, (wr_q.size() != 0)});
    if (wr_q.size() != 0) chk("usb_out_data", uodata, wr_q[0]);
    chk("proto_err", {5'b0, err}, {5'b0, m_err});
    if (!i_rdn && !e_rxf) void'(rd_q.pop_front());
    if (i_uv && e_uacc) rd_q.push_back(i_ud);
    if ((wr_q.size() != 0) && i_acc) void'(wr_q.pop_front());
    if (!i_wrn && !e_txe) wr_q.push_back(i_wd);
    m_err = m_err | {(!i_oen && !i_wrn), (!i_rdn && !i_wrn), (!i_rdn && i_oen)};
    @(posedge clk);
    m_ready = 1'b1;
  endtask

  // Reset with a usb_in byte offered; both instances must stay idle
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    rdn = 1'b1; wrn = 1'b1; oen = 1'b1; acc = 1'b0; uv = 1'b1; ud = 8'hA5; wd = 8'h00;
    rdn_b = 1'b1; oen_b = 1'b1; uv_b = 1'b1; ud_b = 8'hA5;
    #1;
    chk("rst_rxf", {7'b0, rxf}, 8'h01);
    chk("rst_txe", {7'b0, txe}, 8'h01);
    chk("rst_accept", {7'b0, uacc}, 8'h00);
    chk("rst_err", {5'b0, err}, 8'h00);
    chk("rst_data_out", dout, 8'h00);
    chk("rst_out_valid", {7'b0, uovalid}, 8'h00);
    chk("rst_data_oe", {7'b0, doe}, 8'h00);
    chk("rst_b_rxf", {7'b0, rxf_b}, 8'h01);
    chk("rst_b_txe", {7'b0, txe_b}, 8'h01);
    chk("rst_b_accept", {7'b0, uacc_b}, 8'h00);
    chk("rst_b_out_valid", {7'b0, uovalid_b}, 8'h00);
    chk("rst_b_err", {5'b0, err_b}, 8'h00);
    chk("rst_b_data_oe", {7'b0, doe_b}, 8'h00);
    chk("rst_b_data_out", dout_b, 8'h00);
    rd_q.delete();
    wr_q.delete();
    m_err = 3'b000;
    m_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    uv = 1'b0; uv_b = 1'b0;
    #1;
    chk("pre_ready_txe", {7'b0, txe}, 8'h01);
    chk("pre_ready_accept", {7'b0, uacc}, 8'h00);
    @(posedge clk);
    m_ready = 1'b1;
  endtask

  initial begin
    logic [7:0] nxt;
    logic       pat[16];
    logic [31:0] r;

    rst_n = 1'b0;
    rdn = 1'b1; wrn = 1'b1; oen = 1'b1; uv = 1'b0; acc = 1'b0; ud = 8'h00; wd = 8'h00;
    rdn_b = 1'b1; oen_b = 1'b1; uv_b = 1'b0; ud_b = 8'h00;
    m_ready = 1'b0;
    m_err = 3'b000;

    vt[0] = '{1'b1, 1'b1, 1'b1, 3'b000};
    vt[1] = '{1'b0, 1'b1, 1'b1, 3'b001};
    vt[2] = '{1'b1, 1'b1, 1'b0, 3'b001};
    vt[3] = '{1'b0, 1'b0, 1'b1, 3'b011};
    vt[4] = '{1'b1, 1'b1, 1'b1, 3'b011};

    do_reset();

    // Five bytes in, then host reads them with OE# and RD# low
    for (int i = 1; i <= 5; i++) step(1'b1, 1'b1, 1'b1, 1'b1, 8'(i), 8'h00, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Simultaneous push and pop at level one
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h22, 8'h00, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

    // Fill the out-FIFO with no USB drain, then drain it
    for (int i = 0; i < 70; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'(i), 1'b0);
    #1 chk("txe_after_fill", {7'b0, txe}, 8'h01);
    for (int i = 0; i < 66; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1);
    #1 chk("txe_after_drain", {7'b0, txe}, 8'h00);

    // Burst shaping on instance B: 10 bytes, RD# held low
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      uv_b = 1'b1; ud_b = 8'(i);
      #1 chk("b_accept", {7'b0, uacc_b}, 8'h01);
    end
    @(negedge clk);
    uv_b = 1'b0;
    pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
            1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    nxt = 8'd1;
    rdn_b = 1'b0; oen_b = 1'b0;
    for (int c = 0; c < 16; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      chk("b_rxf", {7'b0, rxf_b}, {7'b0, pat[c]});
      if (!pat[c]) begin
        chk("b_data", dout_b, nxt);
        nxt = nxt + 8'd1;
      end
    end
    #1 chk("b_err", {5'b0, err_b}, 8'h00);
    @(negedge clk);
    rdn_b = 1'b1; oen_b = 1'b1;

    // Protocol error table: flags accumulate and stay set
    for (int i = 0; i < 5; i++) begin
      step(vt[i].rdn, vt[i].wrn, vt[i].oen, 1'b0, 8'h00, 8'h5A, 1'b1);
      #1 chk("err_vec", {5'b0, err}, {5'b0, vt[i].err_after});
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1);

    // Reset mid-transfer discards buffered bytes and clears errors
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 8'(8'h40 + i), 8'(8'h80 + i), 1'b0);
    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0);

    // Random traffic with backpressure on both streams, legal bus strobes only
    for (int i = 0; i < 600; i++) begin
      r = $urandom;
      step(r[0], r[0] ? r[1] : 1'b1, r[0], r[2] | r[3], r[15:8], r[23:16], r[4] & r[5]);
    end
    for (int i = 0; i < 140; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    #1 chk("final_err", {5'b0, err}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
